// File: rtl/ov7670_cfg_seq_pkg.sv
// Shared constants, defaults and FSM encoding for the OV7670 configuration sequencer.
// Table entries are 16-bit {register address, register data}.
package ov7670_cfg_seq_pkg;

  localparam logic [6:0]  c_ov7670_id  = 7'h21;
  localparam logic [7:0]  c_end_addr   = 8'hFF;
  localparam logic [7:0]  c_end_data   = 8'hFF;
  localparam logic [7:0]  c_delay_addr = 8'hFE;
  localparam logic [15:0] c_end_entry  = {c_end_addr, c_end_data};

  localparam int c_def_nb_idx         = 8;
  localparam int c_def_pwrup_cycles   = 100_000;
  localparam int c_def_delay_cycles   = 100_000;
  localparam int c_def_timeout_cycles = 20_000;
  localparam int c_def_nb_cnt         = 17;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_FETCH,
    ST_DECODE,
    ST_REQ,
    ST_WAIT_FIN,
    ST_DELAY,
    ST_DONE,
    ST_ERR
  } cfg_state_t;

  function automatic logic is_end_entry(input logic [15:0] entry);
    return entry == c_end_entry;
  endfunction

  function automatic logic is_delay_entry(input logic [15:0] entry);
    return entry[15:8] == c_delay_addr;
  endfunction

endpackage

// File: rtl/ov7670_cfg_seq_regs_rom.sv
// Synchronous register-table ROM: index in, {addr, data} out one clock later.
// Unused slots read as the END marker so a short table always terminates.
module ov7670_regs_rom
  import ov7670_cfg_seq_pkg::*;
#(
  parameter int c_nb_idx = c_def_nb_idx
) (
  input  logic                clk,
  input  logic [c_nb_idx-1:0] idx,
  output logic [15:0]         entry
);

  localparam int c_depth   = 2 ** c_nb_idx;
  localparam int c_nb_used = 11;

  localparam logic [15:0] c_table [c_nb_used] = '{
    16'h1280,                 // COM7: soft reset, needs the settle delay below
    {c_delay_addr, 8'h00},
    16'h1214,                 // COM7: QVGA, RGB
    16'h40D0,                 // COM15: RGB565, full range
    16'h1101,                 // CLKRC: prescale by 2
    16'h0C04,                 // COM3: scaling enable
    16'h3E19,                 // COM14: PCLK divide for QVGA
    16'h703A,                 // SCALING_XSC
    16'h7135,                 // SCALING_YSC
    16'h8C00,                 // RGB444 off
    c_end_entry
  };

  logic [15:0] rom [c_depth];

  for (genvar gi = 0; gi < c_depth; gi++) begin : g_rom
    if (gi < c_nb_used) begin : g_used
      assign rom[gi] = c_table[gi];
    end else begin : g_pad
      assign rom[gi] = c_end_entry;
    end
  end

  always_ff @(posedge clk) begin
    entry <= rom[idx];
  end

endmodule

// File: rtl/ov7670_cfg_seq.sv
// Walks the OV7670 register table and issues one SCCB write per entry,
// with power-up / marker delays and a per-write completion timeout.
module ov7670_cfg_seq
  import ov7670_cfg_seq_pkg::*;
#(
  parameter logic [6:0] c_id             = c_ov7670_id,
  parameter int         c_nb_idx         = c_def_nb_idx,
  parameter int         c_pwrup_cycles   = c_def_pwrup_cycles,
  parameter int         c_delay_cycles   = c_def_delay_cycles,
  parameter int         c_timeout_cycles = c_def_timeout_cycles,
  parameter int         c_nb_cnt         = c_def_nb_cnt
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_cfg,
  input  logic                sccb_ready,
  input  logic                sccb_finish_tx,
  output logic                sccb_start_tx,
  output logic [6:0]          sccb_id,
  output logic [7:0]          sccb_addr,
  output logic [7:0]          sccb_data_wr,
  output logic                cfg_busy,
  output logic                cfg_done,
  output logic                cfg_err,
  output logic [c_nb_idx-1:0] cfg_idx
);

  // Counter loads are N-1 so a phase lasts exactly N cycles ending at zero.
  localparam logic [c_nb_cnt-1:0] c_pwrup_load   = c_nb_cnt'(c_pwrup_cycles - 1);
  localparam logic [c_nb_cnt-1:0] c_delay_load   = c_nb_cnt'(c_delay_cycles - 1);
  localparam logic [c_nb_cnt-1:0] c_timeout_load = c_nb_cnt'(c_timeout_cycles - 1);

  cfg_state_t          state_reg, state_next;
  logic [c_nb_cnt-1:0] cnt_reg, cnt_next;
  logic [c_nb_idx-1:0] idx_reg, idx_next;
  logic [7:0]          addr_reg, addr_next;
  logic [7:0]          data_reg, data_next;
  logic                start_reg, start_next;
  logic [15:0]         rom_entry;
  logic                cnt_zero;
  logic                idx_last;

  ov7670_regs_rom #(
    .c_nb_idx (c_nb_idx)
  ) u_rom (
    .clk   (clk),
    .idx   (idx_reg),
    .entry (rom_entry)
  );

  assign cnt_zero = (cnt_reg == '0);
  assign idx_last = &idx_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      start_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      start_reg <= start_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    start_next = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_cfg) begin
          state_next = ST_PWRUP;
          cnt_next   = c_pwrup_load;
          idx_next   = '0;
        end
      end
      ST_PWRUP: begin
        if (cnt_zero) begin
          state_next = ST_FETCH;
          idx_next   = '0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_FETCH: state_next = ST_DECODE;
      ST_DECODE: begin
        if (is_end_entry(rom_entry)) begin
          state_next = ST_DONE;
        end else if (is_delay_entry(rom_entry)) begin
          state_next = ST_DELAY;
          cnt_next   = c_delay_load;
        end else begin
          state_next = ST_REQ;
          addr_next  = rom_entry[15:8];
          data_next  = rom_entry[7:0];
        end
      end
      ST_REQ: begin
        if (sccb_ready) begin
          state_next = ST_WAIT_FIN;
          start_next = 1'b1;
          cnt_next   = c_timeout_load;
        end
      end
      ST_WAIT_FIN: begin
        // A finish on the terminal-count cycle still counts as success.
        if (sccb_finish_tx) begin
          state_next = idx_last ? ST_DONE : ST_FETCH;
          if (!idx_last) idx_next = idx_reg + 1'b1;
        end else if (cnt_zero) begin
          state_next = ST_ERR;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_DELAY: begin
        if (cnt_zero) begin
          state_next = idx_last ? ST_DONE : ST_FETCH;
          if (!idx_last) idx_next = idx_reg + 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign sccb_start_tx = start_reg;
  assign sccb_id       = c_id;
  assign sccb_addr     = addr_reg;
  assign sccb_data_wr  = data_reg;
  assign cfg_idx       = idx_reg;
  assign cfg_done      = (state_reg == ST_DONE);
  assign cfg_err       = (state_reg == ST_ERR);
  assign cfg_busy      = !(state_reg inside {ST_IDLE, ST_DONE, ST_ERR});

endmodule
